// File: rtl/rtc_bcd_core.sv
// BCD hours/minutes/seconds clock with 12/24-hour presentation and set inputs.
// Time and sec_tick change one cycle after the sampling edge; no backpressure, set inputs act every cycle they are high.
module rtc_bcd_core #(
    parameter int TICK_DIV = 100000000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_24,
    input  logic       set_hr,
    input  logic       set_min,
    input  logic       clr_sec,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_tick,
    output logic       blink
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_nx;

    logic [3:0] h_tens, h_units;
    logic [3:0] m_tens, m_units;
    logic [3:0] s_tens, s_units;

    logic [3:0] h_tens_nx, h_units_nx;
    logic [3:0] m_tens_nx, m_units_nx;
    logic [3:0] s_tens_nx, s_units_nx;

    logic tick;
    logic any_set;
    logic tick_adv;
    logic s_last, m_last, h_last;
    logic sec_inc, min_inc, hr_inc;

    logic [7:0] h24;
    logic [7:0] hr12;

    assign tick     = run && (prescaler == PRESC_LAST);
    assign any_set  = set_hr || set_min || clr_sec;
    // A set input in the same cycle swallows the tick; that second is lost.
    assign tick_adv = tick && !any_set;

    assign s_last = (s_tens == 4'd5) && (s_units == 4'd9);
    assign m_last = (m_tens == 4'd5) && (m_units == 4'd9);
    assign h_last = (h_tens == 4'd2) && (h_units == 4'd3);

    always_comb begin
        prescaler_nx = prescaler;
        if (clr_sec) begin
            prescaler_nx = '0;
        end else if (run) begin
            if (prescaler == PRESC_LAST) begin
                prescaler_nx = '0;
            end else begin
                prescaler_nx = prescaler + PW'(1);
            end
        end
    end

    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        hr_inc  = 1'b0;
        if (tick_adv) begin
            sec_inc = 1'b1;
            min_inc = s_last;
            hr_inc  = s_last && m_last;
        end else begin
            min_inc = set_min;
            hr_inc  = set_hr;
        end
    end

    always_comb begin
        s_tens_nx  = s_tens;
        s_units_nx = s_units;
        if (clr_sec) begin
            s_tens_nx  = 4'd0;
            s_units_nx = 4'd0;
        end else if (sec_inc) begin
            if (s_last) begin
                s_tens_nx  = 4'd0;
                s_units_nx = 4'd0;
            end else if (s_units == 4'd9) begin
                s_tens_nx  = s_tens + 4'd1;
                s_units_nx = 4'd0;
            end else begin
                s_units_nx = s_units + 4'd1;
            end
        end
    end

    always_comb begin
        m_tens_nx  = m_tens;
        m_units_nx = m_units;
        if (min_inc) begin
            if (m_last) begin
                m_tens_nx  = 4'd0;
                m_units_nx = 4'd0;
            end else if (m_units == 4'd9) begin
                m_tens_nx  = m_tens + 4'd1;
                m_units_nx = 4'd0;
            end else begin
                m_units_nx = m_units + 4'd1;
            end
        end
    end

    always_comb begin
        h_tens_nx  = h_tens;
        h_units_nx = h_units;
        if (hr_inc) begin
            if (h_last) begin
                h_tens_nx  = 4'd0;
                h_units_nx = 4'd0;
            end else if (h_units == 4'd9) begin
                h_tens_nx  = h_tens + 4'd1;
                h_units_nx = 4'd0;
            end else begin
                h_units_nx = h_units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            h_tens    <= 4'd0;
            h_units   <= 4'd0;
            m_tens    <= 4'd0;
            m_units   <= 4'd0;
            s_tens    <= 4'd0;
            s_units   <= 4'd0;
            sec_tick  <= 1'b0;
            blink     <= 1'b0;
        end else begin
            prescaler <= prescaler_nx;
            h_tens    <= h_tens_nx;
            h_units   <= h_units_nx;
            m_tens    <= m_tens_nx;
            m_units   <= m_units_nx;
            s_tens    <= s_tens_nx;
            s_units   <= s_units_nx;
            sec_tick  <= tick_adv;
            blink     <= (prescaler >= PRESC_HALF);
        end
    end

    assign h24 = {h_tens, h_units};

    // 12-hour view: 00 -> 12, 13..19 -> 01..07, 20..21 -> 08..09, 22..23 -> 10..11.
    always_comb begin
        hr12 = h24;
        if (h24 == 8'h00) begin
            hr12 = 8'h12;
        end else if (h_tens == 4'd2) begin
            if (h_units < 4'd2) begin
                hr12 = {4'h0, h_units + 4'd8};
            end else begin
                hr12 = {4'h1, h_units - 4'd2};
            end
        end else if (h24 >= 8'h13) begin
            hr12 = {4'h0, h_units - 4'd2};
        end
    end

    assign hr_bcd  = mode_24 ? h24 : hr12;
    assign pm      = !mode_24 && (h24 >= 8'h12);
    assign min_bcd = {m_tens, m_units};
    assign sec_bcd = {s_tens, s_units};

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Bench for rtc_bcd_core at TICK_DIV=4: directed scenarios plus random stimulus
// checked against a seconds-of-day reference model.
module tb_rtc_bcd_core;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       mode_24 = 1'b0;
    logic       set_hr = 1'b0;
    logic       set_min = 1'b0;
    logic       clr_sec = 1'b0;
    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       pm;
    logic       sec_tick;
    logic       blink;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time of day in seconds plus phase within the second.
    int mt    = 0;
    int mph   = 0;
    bit mtick = 1'b0;
    bit mblink = 1'b0;

    always #5 clk = ~clk;

    rtc_bcd_core #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode_24  (mode_24),
        .set_hr   (set_hr),
        .set_min  (set_min),
        .clr_sec  (clr_sec),
        .hr_bcd   (hr_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .pm       (pm),
        .sec_tick (sec_tick),
        .blink    (blink)
    );

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic logic [7:0] exp_hr();
        int h;
        h = mt / 3600;
        if (mode_24) return bcd(h);
        return bcd((h % 12 == 0) ? 12 : (h % 12));
    endfunction

    function automatic logic exp_pm();
        return !mode_24 && ((mt / 3600) >= 12);
    endfunction

    task automatic model_update();
        int  h, mi, s;
        bit  tk, any;
        if (rst) begin
            mt = 0; mph = 0; mtick = 1'b0; mblink = 1'b0;
        end else begin
            tk     = run && (mph == TD - 1);
            any    = set_hr || set_min || clr_sec;
            mblink = (mph >= TD / 2);
            mtick  = tk && !any;
            if (mtick) begin
                mt = (mt + 1) % 86400;
            end else begin
                h  = mt / 3600;
                mi = (mt / 60) % 60;
                s  = mt % 60;
                if (set_hr)  h  = (h + 1) % 24;
                if (set_min) mi = (mi + 1) % 60;
                if (clr_sec) s  = 0;
                mt = h * 3600 + mi * 60 + s;
            end
            if (clr_sec)  mph = 0;
            else if (run) mph = (mph + 1) % TD;
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic cyc(input bit r, input bit ru, input bit sh, input bit sm, input bit cs);
        rst = r; run = ru; set_hr = sh; set_min = sm; clr_sec = cs;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        cyc(1, 0, 0, 0, 0);
        repeat (h) cyc(0, 0, 1, 0, 0);
        repeat (m) cyc(0, 0, 0, 1, 0);
        repeat (s * TD) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(0, 1, 0, 0, 0);
            n++;
        end while (!sec_tick && n < 20);
    endtask

    task automatic test_reset();
        mode_24 = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        n_checks++; if (hr_bcd !== 8'h12) $display("FAIL reset_hr: got %h expected 12", hr_bcd); else n_pass++;
        n_checks++; if (min_bcd !== 8'h00) $display("FAIL reset_min: got %h expected 00", min_bcd); else n_pass++;
        n_checks++; if (sec_bcd !== 8'h00) $display("FAIL reset_sec: got %h expected 00", sec_bcd); else n_pass++;
        n_checks++; if (pm !== 1'b0) $display("FAIL reset_pm: got %b expected 0", pm); else n_pass++;
        n_checks++; if (sec_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", sec_tick); else n_pass++;
        n_checks++; if (blink !== 1'b0) $display("FAIL reset_blink: got %b expected 0", blink); else n_pass++;
        mode_24 = 1'b1; #1;
        n_checks++; if (hr_bcd !== 8'h00) $display("FAIL reset_hr24: got %h expected 00", hr_bcd); else n_pass++;
        mode_24 = 1'b0;
    endtask

    task automatic test_first_tick();
        int n;
        int highs;
        int ticks;
        wait_tick(n);
        n_checks++; if (n !== 4) $display("FAIL first_tick_latency: got %0d expected 4", n); else n_pass++;
        n_checks++; if (sec_bcd !== 8'h01) $display("FAIL first_tick_sec: got %h expected 01", sec_bcd); else n_pass++;
        highs = 0; ticks = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (blink) highs++;
            if (sec_tick) ticks++;
            n_checks++; if (sec_bcd !== bcd(mt % 60)) $display("FAIL steady_sec: got %h expected %h", sec_bcd, bcd(mt % 60)); else n_pass++;
            n_checks++; if (blink !== mblink) $display("FAIL steady_blink: got %b expected %b", blink, mblink); else n_pass++;
        end
        n_checks++; if (highs !== 8) $display("FAIL blink_duty: got %0d expected 8", highs); else n_pass++;
        n_checks++; if (ticks !== 4) $display("FAIL tick_rate: got %0d expected 4", ticks); else n_pass++;
    endtask

    task automatic test_rollover();
        int n;
        mode_24 = 1'b0;
        goto_time(11, 59, 59);
        wait_tick(n);
        n_checks++; if (n !== 4) $display("FAIL roll11_latency: got %0d expected 4", n); else n_pass++;
        n_checks++; if (hr_bcd !== 8'h12) $display("FAIL roll11_hr: got %h expected 12", hr_bcd); else n_pass++;
        n_checks++; if ({min_bcd, sec_bcd} !== 16'h0000) $display("FAIL roll11_ms: got %h expected 0000", {min_bcd, sec_bcd}); else n_pass++;
        n_checks++; if (pm !== 1'b1) $display("FAIL roll11_pm: got %b expected 1", pm); else n_pass++;
        goto_time(23, 59, 59);
        wait_tick(n);
        n_checks++; if (hr_bcd !== 8'h12) $display("FAIL roll23_hr12: got %h expected 12", hr_bcd); else n_pass++;
        n_checks++; if (pm !== 1'b0) $display("FAIL roll23_pm: got %b expected 0", pm); else n_pass++;
        n_checks++; if ({min_bcd, sec_bcd} !== 16'h0000) $display("FAIL roll23_ms: got %h expected 0000", {min_bcd, sec_bcd}); else n_pass++;
        mode_24 = 1'b1; #1;
        n_checks++; if (hr_bcd !== 8'h00) $display("FAIL roll23_hr24: got %h expected 00", hr_bcd); else n_pass++;
        mode_24 = 1'b0;
    endtask

    task automatic test_set_wraps();
        int n;
        mode_24 = 1'b1;
        goto_time(23, 0, 0);
        cyc(0, 0, 1, 0, 0);
        n_checks++; if (hr_bcd !== 8'h00) $display("FAIL set_hr_wrap: got %h expected 00", hr_bcd); else n_pass++;
        goto_time(5, 59, 0);
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (min_bcd !== 8'h00) $display("FAIL set_min_wrap: got %h expected 00", min_bcd); else n_pass++;
        n_checks++; if (hr_bcd !== 8'h05) $display("FAIL set_min_nocarry: got %h expected 05", hr_bcd); else n_pass++;
        goto_time(0, 0, 37);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        n_checks++; if (sec_bcd !== 8'h00) $display("FAIL clr_sec: got %h expected 00", sec_bcd); else n_pass++;
        wait_tick(n);
        n_checks++; if (n !== 4) $display("FAIL clr_sec_phase: got %0d expected 4", n); else n_pass++;
        n_checks++; if (sec_bcd !== 8'h01) $display("FAIL clr_sec_next: got %h expected 01", sec_bcd); else n_pass++;
    endtask

    task automatic test_collision();
        mode_24 = 1'b1;
        goto_time(0, 10, 20);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        n_checks++; if (min_bcd !== 8'h11) $display("FAIL coll_min: got %h expected 11", min_bcd); else n_pass++;
        n_checks++; if (sec_bcd !== 8'h20) $display("FAIL coll_sec: got %h expected 20", sec_bcd); else n_pass++;
        n_checks++; if (sec_tick !== 1'b0) $display("FAIL coll_tick: got %b expected 0", sec_tick); else n_pass++;
        cyc(0, 1, 1, 1, 1);
        n_checks++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h011200) $display("FAIL all_sets: got %h expected 011200", {hr_bcd, min_bcd, sec_bcd}); else n_pass++;
    endtask

    task automatic test_freeze_and_reset();
        int n;
        mode_24 = 1'b1;
        goto_time(1, 2, 3);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            n_checks++;
            if ({hr_bcd, min_bcd, sec_bcd, sec_tick, blink} !== {24'h010203, 2'b00})
                $display("FAIL freeze: got %h/%b/%b expected 010203/0/0", {hr_bcd, min_bcd, sec_bcd}, sec_tick, blink);
            else n_pass++;
        end
        wait_tick(n);
        n_checks++; if (n !== 3) $display("FAIL resume_phase: got %0d expected 3", n); else n_pass++;
        n_checks++; if (sec_bcd !== 8'h04) $display("FAIL resume_sec: got %h expected 04", sec_bcd); else n_pass++;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd, sec_tick, blink} !== {24'h000000, 2'b00})
            $display("FAIL midrun_reset: got %h/%b/%b expected 000000/0/0", {hr_bcd, min_bcd, sec_bcd}, sec_tick, blink);
        else n_pass++;
        mode_24 = 1'b0; #1;
        n_checks++; if ({hr_bcd, pm} !== {8'h12, 1'b0}) $display("FAIL midrun_reset_hr12: got %h/%b expected 12/0", hr_bcd, pm); else n_pass++;
        wait_tick(n);
        n_checks++; if (n !== 4) $display("FAIL midrun_reset_phase: got %0d expected 4", n); else n_pass++;
    endtask

    task automatic test_mode_switch();
        goto_time(13, 0, 0);
        mode_24 = 1'b1; #1;
        n_checks++; if ({hr_bcd, pm} !== {8'h13, 1'b0}) $display("FAIL mode24_13: got %h/%b expected 13/0", hr_bcd, pm); else n_pass++;
        mode_24 = 1'b0; #1;
        n_checks++; if ({hr_bcd, pm} !== {8'h01, 1'b1}) $display("FAIL mode12_13: got %h/%b expected 01/1", hr_bcd, pm); else n_pass++;
        n_checks++; if ({min_bcd, sec_bcd} !== 16'h0000) $display("FAIL mode_nostate: got %h expected 0000", {min_bcd, sec_bcd}); else n_pass++;
    endtask

    task automatic test_random();
        bit r, ru, sh, sm, cs;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            ru = ($urandom_range(0, 9) != 0);
            sh = ($urandom_range(0, 19) == 0);
            sm = ($urandom_range(0, 14) == 0);
            cs = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) mode_24 = ~mode_24;
            cyc(r, ru, sh, sm, cs);
            n_checks++; if (hr_bcd !== exp_hr()) $display("FAIL rnd_hr @%0d: got %h expected %h", i, hr_bcd, exp_hr()); else n_pass++;
            n_checks++; if (min_bcd !== bcd((mt / 60) % 60)) $display("FAIL rnd_min @%0d: got %h expected %h", i, min_bcd, bcd((mt / 60) % 60)); else n_pass++;
            n_checks++; if (sec_bcd !== bcd(mt % 60)) $display("FAIL rnd_sec @%0d: got %h expected %h", i, sec_bcd, bcd(mt % 60)); else n_pass++;
            n_checks++; if (pm !== exp_pm()) $display("FAIL rnd_pm @%0d: got %b expected %b", i, pm, exp_pm()); else n_pass++;
            n_checks++; if (sec_tick !== mtick) $display("FAIL rnd_tick @%0d: got %b expected %b", i, sec_tick, mtick); else n_pass++;
            n_checks++; if (blink !== mblink) $display("FAIL rnd_blink @%0d: got %b expected %b", i, blink, mblink); else n_pass++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_tick();
        test_rollover();
        test_set_wraps();
        test_collision();
        test_freeze_and_reset();
        test_mode_switch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
